// File: rtl/recirc_mux_tx_scheduler.sv
// -----------------------------------------------------------------------------
// recirc_mux_tx_scheduler
//
// Source-domain (A) scheduler that shares one recirculation-mux CDC channel
// between G_REQ requesters. A round-robin arbiter picks one requester. The
// arbiter captures that requester's word onto the channel data bus and then
// fires one launch pulse. The word is held for G_HOLD guard cycles so the
// destination domain can sample it safely. New requests are accepted only
// after the guard interval ends.
//
// Ports:
//   i_clk_A      source-domain clock (the only clock)
//   i_rst_A      asynchronous, active-low reset
//   i_req        per-requester request level, held until granted
//   i_data       packed words; requester k uses [k*G_WIDTH +: G_WIDTH]
//   o_grant      one-hot, single-cycle acceptance strobe
//   o_pulse_A    single-cycle launch pulse to the CDC channel
//   o_data_A     captured word driven to the CDC channel
//   o_busy       high whenever the scheduler is not idle
//   o_xfer_count 16-bit launch counter (only with RECIRC_SCHED_STATS_EN)
//
// Optional feature macro: RECIRC_SCHED_STATS_EN
// -----------------------------------------------------------------------------
module recirc_mux_tx_scheduler #(
    parameter int unsigned G_REQ   = 4,
    parameter int unsigned G_WIDTH = 4,
    parameter int unsigned G_HOLD  = 6
) (
    input  logic                       i_clk_A,
    input  logic                       i_rst_A,
    input  logic [G_REQ-1:0]           i_req,
    input  logic [G_REQ*G_WIDTH-1:0]   i_data,
    output logic [G_REQ-1:0]           o_grant,
    output logic                       o_pulse_A,
    output logic [G_WIDTH-1:0]         o_data_A,
    output logic                       o_busy
`ifdef RECIRC_SCHED_STATS_EN
    ,
    output logic [15:0]                o_xfer_count
`endif
);

    localparam int unsigned PW = (G_REQ > 1) ? $clog2(G_REQ) : 1;
    localparam int unsigned CW = $clog2(G_HOLD + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [G_REQ-1:0]    grant_q, grant_d;
    logic                pulse_q, pulse_d;
    logic [G_WIDTH-1:0]  data_q, data_d;
    logic                busy_q, busy_d;

    // Unpacked view of the packed request words.
    logic [G_WIDTH-1:0]  words [G_REQ];

    for (genvar k = 0; k < G_REQ; k++) begin : g_words
        assign words[k] = i_data[k*G_WIDTH +: G_WIDTH];
    end

    // Round-robin search: the first set request at or above the pointer,
    // wrapping modulo G_REQ.
    logic          found;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;

    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < G_REQ; i++) begin
            idx = PW'((32'(ptr_q) + i) % G_REQ);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        grant_d = '0;
        pulse_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    data_d  = words[win];
                    grant_d = G_REQ'(1) << win;
                    ptr_d   = PW'((32'(win) + 1) % G_REQ);
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Pulse is registered here, so it is visible during the
                // first HOLD cycle. That is one cycle after the grant.
                pulse_d = 1'b1;
                cnt_d   = CW'(G_HOLD - 1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge i_clk_A or negedge i_rst_A) begin
        if (!i_rst_A) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            pulse_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            pulse_q <= pulse_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_pulse_A = pulse_q;
    assign o_data_A  = data_q;
    assign o_busy    = busy_q;

`ifdef RECIRC_SCHED_STATS_EN
    logic [15:0] xfer_q;

    always_ff @(posedge i_clk_A or negedge i_rst_A) begin
        if (!i_rst_A) begin
            xfer_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            xfer_q <= xfer_q + 16'd1;
        end
    end

    assign o_xfer_count = xfer_q;
`endif

endmodule

// File: tb/tb_recirc_mux_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_recirc_mux_tx_scheduler
//
// Directed bench for recirc_mux_tx_scheduler with its default parameters
// (G_REQ=4, G_WIDTH=4, G_HOLD=6). Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_recirc_mux_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  grant;
    logic        pulse;
    logic [3:0]  data_a;
    logic        busy;
`ifdef RECIRC_SCHED_STATS_EN
    logic [15:0] xfer_count;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    recirc_mux_tx_scheduler #(
        .G_REQ   (4),
        .G_WIDTH (4),
        .G_HOLD  (6)
    ) dut (
        .i_clk_A      (clk),
        .i_rst_A      (rst_n),
        .i_req        (req),
        .i_data       (data),
        .o_grant      (grant),
        .o_pulse_A    (pulse),
        .o_data_A     (data_a),
        .o_busy       (busy)
`ifdef RECIRC_SCHED_STATS_EN
        ,
        .o_xfer_count (xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transfer: requests are presented, and one edge later the
    // grant and data must appear. The pulse follows on the next cycle. Then
    // come six silent guard cycles, and the scheduler is idle at step 8.
    task automatic xfer(input logic [3:0] r, input logic [15:0] d, input logic keep_req,
                        input logic [3:0] exp_grant, input logic [3:0] exp_word);
        req  = r;
        data = d;
        step();
        chk("xfer_grant", 16'(grant), 16'(exp_grant));
        chk("xfer_data",  16'(data_a), 16'(exp_word));
        chk("xfer_busy",  16'(busy), 16'd1);
        chk("xfer_nopulse_grant_cycle", 16'(pulse), 16'd0);
        if (!keep_req) req = 4'b0000;
        step();
        chk("xfer_pulse", 16'(pulse), 16'd1);
        chk("xfer_grant_clear", 16'(grant), 16'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("xfer_guard_nopulse", 16'(pulse), 16'd0);
            chk("xfer_guard_nogrant", 16'(grant), 16'd0);
            chk("xfer_guard_data", 16'(data_a), 16'(exp_word));
            chk("xfer_busy_profile", 16'(busy), (i < 5) ? 16'd1 : 16'd0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b1;
        req         = 4'(($urandom));
        data        = 16'($urandom);
        #2;
        rst_n = 1'b0;

        // Reset with random requests: every output stays at zero.
        for (int i = 0; i < 4; i++) begin
            req  = 4'($urandom);
            data = 16'($urandom);
            step();
            chk("rst_grant", 16'(grant), 16'd0);
            chk("rst_pulse", 16'(pulse), 16'd0);
            chk("rst_data",  16'(data_a), 16'd0);
            chk("rst_busy",  16'(busy), 16'd0);
`ifdef RECIRC_SCHED_STATS_EN
            chk("rst_count", xfer_count, 16'd0);
`endif
        end
        req = 4'b0000;
        #2;
        rst_n = 1'b1;

        // Idle: no requests for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_busy",  16'(busy), 16'd0);
            chk("idle_pulse", 16'(pulse), 16'd0);
            chk("idle_grant", 16'(grant), 16'd0);
        end

        // Single request from requester 2. The pointer moves to 3.
        xfer(4'b0100, 16'h0A00, 1'b0, 4'b0100, 4'hA);

        // Pointer 3 with requests {1,0}: the search wraps to requester 0,
        // then requester 1 is served.
        xfer(4'b0011, 16'h0065, 1'b1, 4'b0001, 4'h5);
        xfer(4'b0011, 16'h0065, 1'b0, 4'b0010, 4'h6);

        // Pointer 2 with requests {3,1}: requester 3 wins. The pointer wraps to 0.
        req  = 4'b1010;
        data = 16'h9000;
        step();
        chk("skip_grant3", 16'(grant), 16'b1000);
        chk("skip_data3",  16'(data_a), 16'h9);
        // Requester 1 withdraws while the scheduler is busy, so it is never granted.
        req = 4'b0000;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("skip_nogrant", 16'(grant), 16'd0);
        end
        chk("skip_idle", 16'(busy), 16'd0);

        // All four requesters request continuously. Grants go 0,1,2,3 and the
        // pulses are spaced 8 cycles apart.
        xfer(4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h1);
        xfer(4'b1111, 16'h4321, 1'b1, 4'b0010, 4'h2);
        xfer(4'b1111, 16'h4321, 1'b1, 4'b0100, 4'h3);
        xfer(4'b1111, 16'h4321, 1'b0, 4'b1000, 4'h4);

        // Data stability: word0 changes every cycle after its grant.
        req  = 4'b0001;
        data = 16'h0007;
        step();
        chk("stab_grant", 16'(grant), 16'b0001);
        chk("stab_data0", 16'(data_a), 16'h7);
        req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            data = 16'(i + 8);
            step();
            chk("stab_hold", 16'(data_a), 16'h7);
        end

        // Reset during the pulse cycle: outputs clear without any clock edge.
        // The pointer is now 1 and requester 2 wins.
        req  = 4'b0100;
        data = 16'h0B00;
        step();
        chk("mid_grant", 16'(grant), 16'b0100);
        req = 4'b0000;
        step();
        chk("mid_pulse", 16'(pulse), 16'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pulse", 16'(pulse), 16'd0);
        chk("mid_rst_busy",  16'(busy), 16'd0);
        chk("mid_rst_data",  16'(data_a), 16'd0);
        #2;
        rst_n = 1'b1;

        // After the reset, arbitration restarts from requester 0.
        xfer(4'b1111, 16'hDCBA, 1'b1, 4'b0001, 4'hA);
        xfer(4'b1111, 16'hDCBA, 1'b1, 4'b0010, 4'hB);
        xfer(4'b1111, 16'hDCBA, 1'b1, 4'b0100, 4'hC);
        xfer(4'b1111, 16'hDCBA, 1'b1, 4'b1000, 4'hD);
        xfer(4'b1111, 16'hDCBA, 1'b0, 4'b0001, 4'hA);
`ifdef RECIRC_SCHED_STATS_EN
        chk("stats_count5", xfer_count, 16'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
